// File: rtl/alu_mdu_ctrl.sv
// alu_mdu_ctrl: issue/sequencing controller between the EXE stage and the ALU
// (which contains the multi-cycle multiplier and divider).
//
// Accepts one op per in_valid/in_ready handshake, holds op and operands on the
// ALU until alu_complete, then presents the registered result on out_valid/out_ready.
// flush cancels work; an in-flight mul/div is drained without committing.
// A watchdog aborts ops that never complete.
//
// Ports:
//   clk, resetn                        clock, async active-low reset
//   in_valid/in_ready/in_op/in_src*    request channel
//   flush                              cancel in-flight or pending op
//   alu_op/alu_src*                    drive to the ALU
//   alu_result/alu_complete            ALU response
//   out_valid/out_ready/out_result     result channel
//   busy, last_lat, err_timeout        status
//
// state  | meaning
// -------+-------------------------------------------------------------
// IDLE   | no op held, ALU sees all-zero op
// BUSY   | op driven to ALU, waiting for complete
// DRAIN  | flushed mid mul/div; op held until the unit finishes, no commit
// DONE   | result held on out_result until consumed or flushed
module alu_mdu_ctrl #(
   parameter int OP_W    = 19,
   parameter int DATA_W  = 32,
   parameter int MAX_CYC = 64,
   parameter int CNT_W   = 7
) (
   input  logic              clk,
   input  logic              resetn,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [OP_W-1:0]   in_op,
   input  logic [DATA_W-1:0] in_src1,
   input  logic [DATA_W-1:0] in_src2,
   input  logic              flush,
   output logic [OP_W-1:0]   alu_op,
   output logic [DATA_W-1:0] alu_src1,
   output logic [DATA_W-1:0] alu_src2,
   input  logic [DATA_W-1:0] alu_result,
   input  logic              alu_complete,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_result,
   output logic              busy,
   output logic [CNT_W-1:0]  last_lat,
   output logic              err_timeout
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_BUSY  = 2'd1,
      S_DRAIN = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   state_t              r_state;
   state_t              w_next;
   logic [OP_W-1:0]     r_op;
   logic [DATA_W-1:0]   r_src1;
   logic [DATA_W-1:0]   r_src2;
   logic [DATA_W-1:0]   r_res;
   logic [CNT_W-1:0]    r_cnt;
   logic [CNT_W-1:0]    r_last_lat;
   logic                r_err;

   logic                w_accept;
   logic                w_active;
   logic                w_commit;
   logic                w_wdog;

   assign w_active = (r_state == S_BUSY) || (r_state == S_DRAIN);
   assign in_ready = ~flush & ((r_state == S_IDLE) | ((r_state == S_DONE) & out_ready));
   assign w_accept = in_valid & in_ready;
   assign w_commit = (r_state == S_BUSY) & alu_complete & ~flush;

   // A flush in BUSY defers to DRAIN, so the watchdog only fires there once
   // the flush has been taken. The >= compare keeps DRAIN bounded even if
   // the flush arrived on the terminal count.
   assign w_wdog = (r_cnt >= CNT_W'(MAX_CYC - 1)) & ~alu_complete &
                   (((r_state == S_BUSY) & ~flush) | (r_state == S_DRAIN));

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE: begin
            if (w_accept) w_next = S_BUSY;
         end
         S_BUSY: begin
            if (flush)             w_next = alu_complete ? S_IDLE : S_DRAIN;
            else if (alu_complete) w_next = S_DONE;
            else if (w_wdog)       w_next = S_IDLE;
         end
         S_DRAIN: begin
            if (alu_complete || w_wdog) w_next = S_IDLE;
         end
         S_DONE: begin
            if (w_accept)                w_next = S_BUSY;
            else if (flush || out_ready) w_next = S_IDLE;
         end
         default: w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_state    <= S_IDLE;
         r_op       <= '0;
         r_src1     <= '0;
         r_src2     <= '0;
         r_res      <= '0;
         r_cnt      <= '0;
         r_last_lat <= '0;
         r_err      <= 1'b0;
      end else begin
         r_state <= w_next;
         if (w_accept) begin
            r_op   <= in_op;
            r_src1 <= in_src1;
            r_src2 <= in_src2;
            r_cnt  <= '0;
         end else begin
            if (w_active) r_cnt <= r_cnt + CNT_W'(1);
            if (w_wdog)   r_op  <= '0;
         end
         if (w_commit) begin
            r_res      <= alu_result;
            r_last_lat <= r_cnt + CNT_W'(1);
         end
         if (w_wdog) r_err <= 1'b1;
      end
   end

   assign alu_op      = w_active ? r_op : '0;
   assign alu_src1    = r_src1;
   assign alu_src2    = r_src2;
   assign out_valid   = (r_state == S_DONE);
   assign out_result  = r_res;
   assign busy        = w_active;
   assign last_lat    = r_last_lat;
   assign err_timeout = r_err;

endmodule

// File: tb/tb_alu_mdu_ctrl.sv
// Directed bench for alu_mdu_ctrl with a behavioural ALU stub:
// single-cycle ops complete combinationally, mul/mulh/mulhu complete on the
// 2nd cycle the op is held, div/mod on the 33rd, and never when r_hang is set.
module tb_alu_mdu_ctrl;

   localparam int OP_W = 19, DATA_W = 32, CNT_W = 7;
   localparam logic [OP_W-1:0] OP_ADD   = 19'h00001;
   localparam logic [OP_W-1:0] OP_MUL   = 19'h01000;
   localparam logic [OP_W-1:0] OP_MULHU = 19'h04000;
   localparam logic [OP_W-1:0] OP_DIV   = 19'h08000;
   localparam logic [OP_W-1:0] OP_MODU  = 19'h40000;

   logic              clk = 1'b0;
   logic              resetn = 1'b0;
   logic              in_valid = 1'b0;
   logic              in_ready;
   logic [OP_W-1:0]   in_op = '0;
   logic [DATA_W-1:0] in_src1 = '0;
   logic [DATA_W-1:0] in_src2 = '0;
   logic              flush = 1'b0;
   logic [OP_W-1:0]   alu_op;
   logic [DATA_W-1:0] alu_src1;
   logic [DATA_W-1:0] alu_src2;
   logic [DATA_W-1:0] alu_result;
   logic              alu_complete;
   logic              out_valid;
   logic              out_ready = 1'b0;
   logic [DATA_W-1:0] out_result;
   logic              busy;
   logic [CNT_W-1:0]  last_lat;
   logic              err_timeout;

   int n_tests = 0;
   int n_fail  = 0;
   int cyc;
   logic r_hang = 1'b0;
   int stub_cnt = 0;

   alu_mdu_ctrl dut (
      .clk(clk), .resetn(resetn),
      .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
      .in_src1(in_src1), .in_src2(in_src2), .flush(flush),
      .alu_op(alu_op), .alu_src1(alu_src1), .alu_src2(alu_src2),
      .alu_result(alu_result), .alu_complete(alu_complete),
      .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
      .busy(busy), .last_lat(last_lat), .err_timeout(err_timeout)
   );

   always #5 clk = ~clk;

   // ALU stub
   logic        w_mdu, w_mul;
   logic [63:0] w_prod_u;
   logic [63:0] w_prod_s;
   assign w_mdu    = |alu_op[18:12];
   assign w_mul    = |alu_op[14:12];
   assign w_prod_u = {32'b0, alu_src1} * {32'b0, alu_src2};
   assign w_prod_s = $signed({{32{alu_src1[31]}}, alu_src1}) * $signed({{32{alu_src2[31]}}, alu_src2});

   always @(posedge clk) stub_cnt <= w_mdu ? stub_cnt + 1 : 0;

   always_comb begin
      alu_result = '0;
      if (alu_op[0])  alu_result = alu_src1 + alu_src2;
      if (alu_op[12]) alu_result = w_prod_u[31:0];
      if (alu_op[13]) alu_result = w_prod_s[63:32];
      if (alu_op[14]) alu_result = w_prod_u[63:32];
      if (alu_op[15]) alu_result = $signed(alu_src1) / $signed(alu_src2);
      if (alu_op[16]) alu_result = alu_src1 / alu_src2;
      if (alu_op[17]) alu_result = $signed(alu_src1) % $signed(alu_src2);
      if (alu_op[18]) alu_result = alu_src1 % alu_src2;
      if (!w_mdu)      alu_complete = 1'b1;
      else if (r_hang) alu_complete = 1'b0;
      else if (w_mul)  alu_complete = (stub_cnt >= 1);
      else             alu_complete = (stub_cnt >= 32);
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Present a request and take the accept edge; leaves the DUT in BUSY cycle 1.
   task automatic issue(input logic [OP_W-1:0] op, input logic [31:0] a, input logic [31:0] b);
      in_valid = 1'b1; in_op = op; in_src1 = a; in_src2 = b;
      tick();
      in_valid = 1'b0;
   endtask

   initial begin
      // reset state
      tick(); tick();
      check("rst_out_valid", 64'(out_valid), 64'd0);
      check("rst_busy", 64'(busy), 64'd0);
      check("rst_alu_op", 64'(alu_op), 64'd0);
      check("rst_out_result", 64'(out_result), 64'd0);
      check("rst_last_lat", 64'(last_lat), 64'd0);
      check("rst_err", 64'(err_timeout), 64'd0);
      resetn = 1'b1;
      tick();

      // ADD 5+7
      out_ready = 1'b1;
      check("add_in_ready", 64'(in_ready), 64'd1);
      issue(OP_ADD, 32'h5, 32'h7);
      check("add_busy", 64'(busy), 64'd1);
      check("add_alu_op", 64'(alu_op), 64'(OP_ADD));
      tick();
      check("add_out_valid", 64'(out_valid), 64'd1);
      check("add_result", 64'(out_result), 64'hC);
      check("add_lat", 64'(last_lat), 64'd1);
      tick();
      check("add_idle", 64'(out_valid), 64'd0);

      // MUL then back-to-back MULHU on the DONE cycle
      issue(OP_MUL, 32'hFFFF_FFFF, 32'h2);
      check("mul_busy1", 64'(busy), 64'd1);
      tick();
      check("mul_busy2", 64'(busy), 64'd1);
      tick();
      check("mul_out_valid", 64'(out_valid), 64'd1);
      check("mul_result", 64'(out_result), 64'hFFFF_FFFE);
      check("mul_lat", 64'(last_lat), 64'd2);
      in_valid = 1'b1; in_op = OP_MULHU;
      check("b2b_in_ready", 64'(in_ready), 64'd1);
      tick();
      in_valid = 1'b0;
      check("b2b_alu_op", 64'(alu_op), 64'(OP_MULHU));
      check("b2b_out_valid", 64'(out_valid), 64'd0);
      tick(); tick();
      check("mulhu_result", 64'(out_result), 64'h1);
      check("mulhu_lat", 64'(last_lat), 64'd2);
      tick();

      // DIV 100/7 with out_ready held low
      out_ready = 1'b0;
      issue(OP_DIV, 32'd100, 32'd7);
      cyc = 0;
      while (!out_valid && cyc < 200) begin tick(); cyc++; end
      check("div_cycles", 64'(cyc), 64'd33);
      check("div_lat", 64'(last_lat), 64'd33);
      for (int i = 0; i < 5; i++) begin
         check("div_hold_valid", 64'(out_valid), 64'd1);
         check("div_hold_result", 64'(out_result), 64'd14);
         check("div_hold_in_ready", 64'(in_ready), 64'd0);
         tick();
      end
      out_ready = 1'b1;
      tick();
      check("div_released", 64'(out_valid), 64'd0);

      // flush together with complete in BUSY: discarded
      issue(OP_ADD, 32'd50, 32'd50);
      flush = 1'b1;
      tick();
      flush = 1'b0;
      check("flbusy_valid", 64'(out_valid), 64'd0);
      check("flbusy_busy", 64'(busy), 64'd0);
      check("flbusy_lat", 64'(last_lat), 64'd33);
      check("flbusy_result", 64'(out_result), 64'd14);

      // flush in DONE
      out_ready = 1'b0;
      issue(OP_ADD, 32'd3, 32'd4);
      tick();
      check("fldone_result", 64'(out_result), 64'd7);
      flush = 1'b1;
      #1;
      check("fldone_in_ready", 64'(in_ready), 64'd0);
      check("fldone_valid_hold", 64'(out_valid), 64'd1);
      tick();
      flush = 1'b0;
      check("fldone_valid_drop", 64'(out_valid), 64'd0);

      // all-zero op completes in one cycle with result 0
      out_ready = 1'b1;
      issue('0, 32'd9, 32'd9);
      tick();
      check("zero_valid", 64'(out_valid), 64'd1);
      check("zero_result", 64'(out_result), 64'd0);
      check("zero_lat", 64'(last_lat), 64'd1);
      tick();

      // flush on 3rd BUSY cycle of MODU: drain until complete
      issue(OP_MODU, 32'd100, 32'd7);
      tick(); tick();
      flush = 1'b1;
      #1;
      check("drain_in_ready", 64'(in_ready), 64'd0);
      tick();
      flush = 1'b0;
      cyc = 0;
      while (busy && cyc < 200) begin
         check("drain_alu_op", 64'(alu_op), 64'h40000);
         check("drain_no_valid", 64'(out_valid), 64'd0);
         tick(); cyc++;
      end
      check("drain_cycles", 64'(cyc), 64'd30);
      check("drain_end_op", 64'(alu_op), 64'd0);
      check("drain_end_valid", 64'(out_valid), 64'd0);
      check("drain_lat", 64'(last_lat), 64'd1);

      // hung divider: watchdog
      r_hang = 1'b1;
      issue(OP_DIV, 32'd100, 32'd7);
      check("wd_err_before", 64'(err_timeout), 64'd0);
      cyc = 0;
      while (busy && cyc < 200) begin tick(); cyc++; end
      check("wd_cycles", 64'(cyc), 64'd64);
      check("wd_err", 64'(err_timeout), 64'd1);
      check("wd_alu_op", 64'(alu_op), 64'd0);
      check("wd_no_valid", 64'(out_valid), 64'd0);
      check("wd_in_ready", 64'(in_ready), 64'd1);
      r_hang = 1'b0;
      issue(OP_ADD, 32'd2, 32'd3);
      tick();
      check("wd_sticky_result", 64'(out_result), 64'd5);
      check("wd_sticky_err", 64'(err_timeout), 64'd1);
      tick();

      // reset mid-divide
      issue(OP_DIV, 32'd100, 32'd7);
      tick(); tick();
      resetn = 1'b0;
      #1;
      check("mrst_busy", 64'(busy), 64'd0);
      check("mrst_alu_op", 64'(alu_op), 64'd0);
      check("mrst_src1", 64'(alu_src1), 64'd0);
      check("mrst_src2", 64'(alu_src2), 64'd0);
      check("mrst_result", 64'(out_result), 64'd0);
      check("mrst_lat", 64'(last_lat), 64'd0);
      check("mrst_err", 64'(err_timeout), 64'd0);
      check("mrst_valid", 64'(out_valid), 64'd0);
      tick(); tick();
      resetn = 1'b1;
      tick();
      issue(OP_ADD, 32'd1, 32'd1);
      tick();
      check("post_rst_valid", 64'(out_valid), 64'd1);
      check("post_rst_result", 64'(out_result), 64'd2);
      check("post_rst_lat", 64'(last_lat), 64'd1);
      tick();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
